// File: rtl/rv32i_types.sv
// Shared types and geometry for the cacheline-to-burst memory adapter.
// Imported by the adapter, its beat buffer and the bus interface.
package rv32i_types;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = BEATS * BEAT_W;
    localparam int OFFSET_BITS = 5;
    localparam int BEAT_IDX_W  = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } adapter_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } req_src_t;

    // Clears the byte-within-line offset so the burst starts on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~32'((1 << OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/bmem_line_adapter_if.sv
// Bundle of I-cache, D-cache and burst-memory signals around the line adapter.
// slave is the adapter's view; master is the caches-plus-memory view.
interface bmem_line_adapter_if;
    import rv32i_types::*;

    logic [31:0]       i_line_address;
    logic              i_line_read;
    logic [LINE_W-1:0] i_line_rdata;
    logic              i_line_resp;

    logic [31:0]       d_line_address;
    logic              d_line_read;
    logic              d_line_write;
    logic [LINE_W-1:0] d_line_wdata;
    logic [LINE_W-1:0] d_line_rdata;
    logic              d_line_resp;

    logic [31:0]       bmem_address;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_rdata;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_resp;

    modport slave (
        input  i_line_address, i_line_read,
        output i_line_rdata, i_line_resp,
        input  d_line_address, d_line_read, d_line_write, d_line_wdata,
        output d_line_rdata, d_line_resp,
        output bmem_address, bmem_read, bmem_write, bmem_wdata,
        input  bmem_rdata, bmem_resp
    );

    modport master (
        output i_line_address, i_line_read,
        input  i_line_rdata, i_line_resp,
        output d_line_address, d_line_read, d_line_write, d_line_wdata,
        input  d_line_rdata, d_line_resp,
        input  bmem_address, bmem_read, bmem_write, bmem_wdata,
        output bmem_rdata, bmem_resp
    );

endinterface

// File: rtl/burst_beat_buffer.sv
// One cacheline register plus beat counter: reads fill it beat by beat,
// writes preload it whole and present one beat at a time.
module burst_beat_buffer
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_we,
    input  logic [BEAT_W-1:0] beat_wdata,
    input  logic              advance,
    output logic              last_beat,
    output logic [BEAT_W-1:0] beat_rdata,
    output logic [LINE_W-1:0] line
);

    logic [LINE_W-1:0]     line_q;
    logic [BEAT_IDX_W-1:0] idx_q;

    // NOTE: the line register is reset like any other state here so a
    // response can never expose data left over from before reset.
    // NOTE: sequential state is assigned non-blocking so every reader sees
    // the pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            line_q <= load_line;
            idx_q  <= '0;
        end else begin
            if (beat_we) begin
                line_q[idx_q*BEAT_W +: BEAT_W] <= beat_wdata;
            end
            if (advance) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign beat_rdata = line_q[idx_q*BEAT_W +: BEAT_W];
    assign last_beat  = (idx_q == BEAT_IDX_W'(BEATS - 1));
    assign line       = line_q;

endmodule

// File: rtl/bmem_line_adapter.sv
// Arbitrates I/D cacheline requests onto one 64-bit burst memory port,
// serialising writebacks and reassembling fills into 256-bit lines.
module bmem_line_adapter
    import rv32i_types::*;
(
    input logic                clk,
    input logic                rst,
    bmem_line_adapter_if.slave bus
);

    adapter_state_t state_q, state_d;
    req_src_t       src_q, last_grant_q;
    logic           op_write_q;
    logic [31:0]    addr_q;

    logic              i_req, d_req, grant_d, grant_any, grant_write;
    logic              buf_load, buf_we, buf_advance, last_beat;
    logic [BEAT_W-1:0] beat_rdata;
    logic [LINE_W-1:0] line;

    assign i_req       = bus.i_line_read;
    assign d_req       = bus.d_line_read | bus.d_line_write;
    // On contention the port not served last wins; I-last at reset lets D go first.
    assign grant_d     = d_req && (!i_req || last_grant_q == SRC_I);
    assign grant_any   = i_req | d_req;
    // A D request with read and write both set is handled as a writeback.
    assign grant_write = grant_d && bus.d_line_write;

    burst_beat_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_line  (grant_write ? bus.d_line_wdata : '0),
        .beat_we    (buf_we),
        .beat_wdata (bus.bmem_rdata),
        .advance    (buf_advance),
        .last_beat  (last_beat),
        .beat_rdata (beat_rdata),
        .line       (line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= SRC_I;
            last_grant_q <= SRC_I;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_any) begin
                src_q      <= grant_d ? SRC_D : SRC_I;
                op_write_q <= grant_write;
                addr_q     <= line_align(grant_d ? bus.d_line_address : bus.i_line_address);
            end
            if (state_q == DONE) begin
                last_grant_q <= src_q;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        buf_load         = 1'b0;
        buf_we           = 1'b0;
        buf_advance      = 1'b0;
        bus.bmem_read    = 1'b0;
        bus.bmem_write   = 1'b0;
        bus.bmem_wdata   = '0;
        bus.bmem_address = '0;
        bus.i_line_resp  = 1'b0;
        bus.i_line_rdata = '0;
        bus.d_line_resp  = 1'b0;
        bus.d_line_rdata = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    buf_load = 1'b1;
                    state_d  = grant_write ? WR : RD;
                end
            end
            RD: begin
                bus.bmem_address = addr_q;
                bus.bmem_read    = 1'b1;
                if (bus.bmem_resp) begin
                    buf_we      = 1'b1;
                    buf_advance = 1'b1;
                    if (last_beat) state_d = DONE;
                end
            end
            WR: begin
                bus.bmem_address = addr_q;
                bus.bmem_write   = 1'b1;
                bus.bmem_wdata   = beat_rdata;
                if (bus.bmem_resp) begin
                    buf_advance = 1'b1;
                    if (last_beat) state_d = DONE;
                end
            end
            DONE: begin
                bus.bmem_address = addr_q;
                if (src_q == SRC_I) begin
                    bus.i_line_resp  = 1'b1;
                    bus.i_line_rdata = op_write_q ? '0 : line;
                end else begin
                    bus.d_line_resp  = 1'b1;
                    bus.d_line_rdata = op_write_q ? '0 : line;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed bench for bmem_line_adapter: fills, writebacks, arbitration,
// beat gaps and reset in the middle of a burst.
module tb_bmem_line_adapter;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    bmem_line_adapter_if bus ();
    bmem_line_adapter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Memory model data and per-run observations.
    logic [BEAT_W-1:0] rd_beats[BEATS];
    logic [BEAT_W-1:0] wr_cap[BEATS];
    int                i_pulses, d_pulses, i_resp_cyc, d_resp_cyc, wr_n, rd_n, done_n;
    logic [31:0]       obs_addr;
    logic [LINE_W-1:0] i_data, d_data;
    logic              rd_seen, wr_seen;
    logic [7:0]        order;

    // Drives requests from cycle 0 and plays memory for a fixed window.
    // pat==0: memory answers every cycle after the first bmem_read/write cycle;
    // otherwise bmem_resp is high exactly in cycles whose pat bit is set.
    task automatic run_line(input bit req_i, input bit req_drd, input bit req_dwr,
                            input logic [31:0] addr_i, input logic [31:0] addr_d,
                            input logic [15:0] pat);
        logic prev_busy = 1'b0;
        logic busy, give;
        i_pulses = 0; d_pulses = 0; i_resp_cyc = -1; d_resp_cyc = -1;
        wr_n = 0; rd_n = 0; done_n = 0; order = '0;
        obs_addr = '0; i_data = '0; d_data = '0; rd_seen = 0; wr_seen = 0;
        bus.i_line_address = addr_i;
        bus.d_line_address = addr_d;
        bus.i_line_read    = req_i;
        bus.d_line_read    = req_drd;
        bus.d_line_write   = req_dwr;
        for (int n = 0; n < 40; n++) begin
            busy = bus.bmem_read | bus.bmem_write;
            if (busy) obs_addr = bus.bmem_address;
            rd_seen |= bus.bmem_read;
            wr_seen |= bus.bmem_write;
            if (bus.i_line_resp) begin
                i_pulses++; i_resp_cyc = n; i_data = bus.i_line_rdata;
                bus.i_line_read = 1'b0;
                order = {order[5:0], 2'b01}; done_n++; rd_n = 0; wr_n = 0;
            end
            if (bus.d_line_resp) begin
                d_pulses++; d_resp_cyc = n; d_data = bus.d_line_rdata;
                bus.d_line_read = 1'b0; bus.d_line_write = 1'b0;
                order = {order[5:0], 2'b10}; done_n++; rd_n = 0; wr_n = 0;
            end
            give = (pat == 16'h0) ? (busy && prev_busy) : (n < 16 && pat[n]);
            bus.bmem_resp  = give;
            bus.bmem_rdata = '0;
            if (give && bus.bmem_read && rd_n < BEATS) begin
                bus.bmem_rdata = rd_beats[rd_n];
                rd_n++;
            end
            if (give && bus.bmem_write && wr_n < BEATS) begin
                wr_cap[wr_n] = bus.bmem_wdata;
                wr_n++;
            end
            prev_busy = busy;
            @(negedge clk);
        end
        bus.bmem_resp = 1'b0;
    endtask

    task automatic set_beats(input logic [15:0] tag);
        for (int k = 0; k < BEATS; k++) rd_beats[k] = {tag, 16'h0, 16'hBEEF, 16'(k)};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_line_read = 0; bus.d_line_read = 0; bus.d_line_write = 0;
        bus.i_line_address = 32'hFFFF_FFFF; bus.d_line_address = 32'hFFFF_FFFF;
        bus.d_line_wdata = '1; bus.bmem_resp = 0; bus.bmem_rdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.bmem_address !== 32'h0) $display("FAIL reset_addr: got %h expected 0", bus.bmem_address);
        else passed++;
        total++;
        if ({bus.bmem_read, bus.bmem_write, bus.i_line_resp, bus.d_line_resp} !== 4'b0)
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.bmem_read, bus.bmem_write, bus.i_line_resp, bus.d_line_resp});
        else passed++;
        total++;
        if ({bus.bmem_wdata, bus.i_line_rdata, bus.d_line_rdata} !== '0)
            $display("FAIL reset_data: got nonzero data expected 0");
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        set_beats(16'hA0A0);
        run_line(1, 0, 0, 32'h0000_1234, 32'h0, 16'h0);
        total++;
        if (obs_addr !== 32'h0000_1220) $display("FAIL i_read_addr: got %h expected 00001220", obs_addr);
        else passed++;
        total++;
        if (i_data !== {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]})
            $display("FAIL i_read_data: got %h expected %h", i_data,
                     {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        else passed++;
        total++;
        if (i_pulses !== 1 || d_pulses !== 0)
            $display("FAIL i_read_pulses: got i=%0d d=%0d expected i=1 d=0", i_pulses, d_pulses);
        else passed++;
        total++;
        if (i_resp_cyc !== 6) $display("FAIL i_read_latency: got %0d expected 6", i_resp_cyc);
        else passed++;
        total++;
        if (bus.i_line_rdata !== '0) $display("FAIL i_rdata_idle: got %h expected 0", bus.i_line_rdata);
        else passed++;
    endtask

    task automatic test_d_write();
        logic [BEAT_W-1:0] w[BEATS];
        for (int k = 0; k < BEATS; k++) w[k] = {32'h5757_0000 + 32'(k), 32'hC0DE_0000 + 32'(k)};
        bus.d_line_wdata = {w[3], w[2], w[1], w[0]};
        run_line(0, 0, 1, 32'h0, 32'h8000_0040, 16'h0);
        total++;
        if (obs_addr !== 32'h8000_0040) $display("FAIL d_write_addr: got %h expected 80000040", obs_addr);
        else passed++;
        for (int k = 0; k < BEATS; k++) begin
            total++;
            if (wr_cap[k] !== w[k]) $display("FAIL d_write_beat%0d: got %h expected %h", k, wr_cap[k], w[k]);
            else passed++;
        end
        total++;
        if (d_pulses !== 1 || i_pulses !== 0 || d_data !== '0)
            $display("FAIL d_write_resp: got d=%0d i=%0d data0=%0b expected d=1 i=0 data0=1",
                     d_pulses, i_pulses, d_data == '0);
        else passed++;
        total++;
        if (rd_seen !== 1'b0) $display("FAIL d_write_no_read: got %b expected 0", rd_seen);
        else passed++;
    endtask

    task automatic test_arbitration();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_beats(16'hD1D1);
        run_line(1, 1, 0, 32'h0000_2000, 32'h0000_3000, 16'h0);
        total++;
        if (done_n !== 2 || order[3:0] !== 4'b1001)
            $display("FAIL arb_first: got n=%0d order=%b expected n=2 order=1001", done_n, order[3:0]);
        else passed++;
        total++;
        if (d_data !== i_data || d_data !== {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]})
            $display("FAIL arb_data: got d=%h i=%h", d_data, i_data);
        else passed++;
        run_line(1, 1, 0, 32'h0000_2000, 32'h0000_3000, 16'h0);
        total++;
        if (done_n !== 2 || order[3:0] !== 4'b1001)
            $display("FAIL arb_repeat: got n=%0d order=%b expected n=2 order=1001", done_n, order[3:0]);
        else passed++;
        run_line(0, 1, 0, 32'h0, 32'h0000_3000, 16'h0);
        run_line(1, 1, 0, 32'h0000_2000, 32'h0000_3000, 16'h0);
        total++;
        if (done_n !== 2 || order[3:0] !== 4'b0110)
            $display("FAIL arb_last_grant: got n=%0d order=%b expected n=2 order=0110", done_n, order[3:0]);
        else passed++;
    endtask

    task automatic test_gaps();
        set_beats(16'h6A9A);
        run_line(1, 0, 0, 32'h0000_4444, 32'h0, 16'h009A);
        total++;
        if (i_data !== {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]})
            $display("FAIL gaps_data: got %h expected %h", i_data,
                     {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        else passed++;
        total++;
        if (i_resp_cyc !== 8 || i_pulses !== 1)
            $display("FAIL gaps_latency: got cyc=%0d n=%0d expected cyc=8 n=1", i_resp_cyc, i_pulses);
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        logic stray_bad = 1'b0;
        set_beats(16'h7777);
        bus.i_line_address = 32'h0000_5000;
        bus.i_line_read    = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus.bmem_resp  = (n == 2 || n == 3);
            bus.bmem_rdata = rd_beats[n & 1];
            @(negedge clk);
        end
        rst = 1'b1; bus.i_line_read = 1'b0; bus.bmem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.bmem_read, bus.bmem_write, bus.i_line_resp, bus.d_line_resp} !== 4'b0 ||
            bus.bmem_address !== 32'h0 || {bus.i_line_rdata, bus.d_line_rdata, bus.bmem_wdata} !== '0)
            $display("FAIL rst_mid_outputs: got rd=%b addr=%h expected all 0", bus.bmem_read, bus.bmem_address);
        else passed++;
        for (int n = 0; n < 3; n++) begin
            bus.bmem_resp = 1'b1; bus.bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            @(negedge clk);
            stray_bad |= bus.i_line_resp | bus.d_line_resp | bus.bmem_read | bus.bmem_write;
        end
        bus.bmem_resp = 1'b0;
        total++;
        if (stray_bad !== 1'b0) $display("FAIL rst_stray_resp: got %b expected 0", stray_bad);
        else passed++;
        set_beats(16'h8888);
        run_line(1, 0, 0, 32'h0000_5010, 32'h0, 16'h0);
        total++;
        if (i_pulses !== 1 || i_resp_cyc !== 6 || obs_addr !== 32'h0000_5000 ||
            i_data !== {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]})
            $display("FAIL rst_then_read: got n=%0d cyc=%0d addr=%h expected n=1 cyc=6 addr=00005000",
                     i_pulses, i_resp_cyc, obs_addr);
        else passed++;
    endtask

    task automatic test_read_write_both();
        logic [LINE_W-1:0] wl;
        wl = {64'h3333_3333_0000_0003, 64'h2222_2222_0000_0002,
              64'h1111_1111_0000_0001, 64'h0000_0000_0000_0000};
        bus.d_line_wdata = wl;
        set_beats(16'hBADD);
        run_line(0, 1, 1, 32'h0, 32'h0000_6060, 16'h0);
        total++;
        if (wr_seen !== 1'b1 || rd_seen !== 1'b0)
            $display("FAIL rw_both_kind: got wr=%b rd=%b expected wr=1 rd=0", wr_seen, rd_seen);
        else passed++;
        total++;
        if ({wr_cap[3], wr_cap[2], wr_cap[1], wr_cap[0]} !== wl || d_pulses !== 1 || d_data !== '0)
            $display("FAIL rw_both_data: got %h pulses=%0d expected %h pulses=1",
                     {wr_cap[3], wr_cap[2], wr_cap[1], wr_cap[0]}, d_pulses, wl);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_arbitration();
        test_gaps();
        test_reset_mid_burst();
        test_read_write_both();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
